aes128_dec_iter_fifo: RTL and testbench

// - Iterative AES-128 decryption engine: the inverse of the pipelined encryption datapath.
// - Recovers plaintext from ciphertext produced by that datapath, for on-target result checking and decrypt-side capture.
// - Ciphertext enters and plaintext leaves on valid/ready streams, so it sits directly between the existing 128-bit FIFOs.
// - Expands the key once per key load into an 11-entry round-key store. Then decrypts one block at a time, one inverse round per clock.

---
 rtl/aes_dec_pkg.sv | 67 ++++++
 rtl/aes_inv_round.sv | 48 ++++
 rtl/aes128_dec_iter_fifo.sv | 127 ++++++++++++
 tb/tb_aes128_dec_iter_fifo.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES-128 decrypt helpers: GF(2^8) arithmetic, forward/inverse S-box, rcon table and FSM states.
// Imported by aes_inv_round and aes128_dec_iter_fifo.
package aes_dec_pkg;

  localparam int AES128_NR = 10;

  typedef enum logic [2:0] {IDLE, KEXP, READY, ROUND, OUT} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse computed as a^254, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2;
    logic [7:0] a3;
    logic [7:0] a12;
    logic [7:0] t;
    a2  = gmul(a, a);
    a3  = gmul(a2, a);
    t   = gmul(a3, a3);
    a12 = gmul(t, t);
    t   = gmul(a12, a3);
    for (int i = 0; i < 4; i++) t = gmul(t, t);
    t   = gmul(t, a12);
    return gmul(t, a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless final_i selects the last-round form.
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_i,
  output logic [127:0] next_state
);

  logic [127:0] shifted;
  logic [127:0] keyed;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    shifted = '0;
    keyed   = '0;
    mixed   = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    // Byte k sits at row k%4, column k/4; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = state[127-8*(4*((c+4-r)%4)+r) -: 8];
      end
    end
    for (int k = 0; k < 16; k++) begin
      keyed[127-8*k -: 8] = inv_sbox(shifted[127-8*k -: 8]) ^ round_key[127-8*k -: 8];
    end
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[127-32*c -: 8];
      a1 = keyed[119-32*c -: 8];
      a2 = keyed[111-32*c -: 8];
      a3 = keyed[103-32*c -: 8];
      mixed[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      mixed[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      mixed[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      mixed[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
  end

  assign next_state = final_i ? keyed : mixed;

endmodule

// File: rtl/aes128_dec_iter_fifo.sv
// Iterative AES-128 decryptor between valid/ready FIFOs: 10-cycle key expansion into rk[0:10], then one
// inverse round per clock. Define AES_DEC_TRIG_EN to build the ROUND-aligned capture trigger on trigger_o.
module aes128_dec_iter_fifo
  import aes_dec_pkg::*;
#(
  parameter int pROUNDS = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_load,
  input  logic [127:0] key_i,
  output logic         key_ready,
  input  logic         ct_valid,
  output logic         ct_ready,
  input  logic [127:0] ct_i,
  output logic         pt_valid,
  input  logic         pt_ready,
  output logic [127:0] pt_o,
  output logic         busy_o,
  output logic         trigger_o
);

  if (pROUNDS != AES128_NR) begin : g_rounds_check
    $error("aes128_dec_iter_fifo supports only pROUNDS = 10 (AES-128)");
  end

  state_t       fsm;
  logic [3:0]   ctr;
  logic [127:0] rk [0:AES128_NR];
  logic [127:0] st;
  logic [127:0] rnd_key, rnd_next, kexp_prev, kexp_next;
  logic [31:0]  kexp_t, w0, w1, w2, w3;
  logic         key_take, accept, last_round;

  assign key_ready  = (fsm == IDLE) || (fsm == READY);
  assign ct_ready   = (fsm == READY) && !key_load;
  assign pt_valid   = (fsm == OUT);
  assign busy_o     = (fsm == KEXP) || (fsm == ROUND);
  assign key_take   = key_ready && key_load;
  assign accept     = ct_ready && ct_valid;
  assign last_round = (fsm == ROUND) && (ctr == 4'd0);

  // Key schedule step: rk[ctr] from rk[ctr-1], SubWord(RotWord(w3)) ^ rcon seeds the word chain.
  assign kexp_prev = rk[ctr - 4'd1];
  assign kexp_t    = {sbox(kexp_prev[23:16]), sbox(kexp_prev[15:8]),
                      sbox(kexp_prev[7:0]), sbox(kexp_prev[31:24])} ^ {rcon(ctr), 24'h0};
  assign w0        = kexp_prev[127:96] ^ kexp_t;
  assign w1        = kexp_prev[95:64] ^ w0;
  assign w2        = kexp_prev[63:32] ^ w1;
  assign w3        = kexp_prev[31:0] ^ w2;
  assign kexp_next = {w0, w1, w2, w3};

  // In ROUND the counter doubles as the round-key index r.
  assign rnd_key = rk[ctr];

  aes_inv_round u_round (
    .state      (st),
    .round_key  (rnd_key),
    .final_i    (ctr == 4'd0),
    .next_state (rnd_next)
  );

  // Round keys and working state carry no reset; fsm decides when their contents are meaningful.
  always_ff @(posedge clk) begin
    if (key_take) rk[0] <= key_i;
    if (fsm == KEXP) rk[ctr] <= kexp_next;
    if (accept) st <= ct_i ^ rk[AES128_NR];
    else if (fsm == ROUND) st <= rnd_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm  <= IDLE;
      ctr  <= '0;
      pt_o <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (key_take) begin
            fsm <= KEXP;
            ctr <= 4'd1;
          end
        end
        KEXP: begin
          if (ctr == 4'(AES128_NR)) fsm <= READY;
          else ctr <= ctr + 4'd1;
        end
        READY: begin
          if (key_take) begin
            fsm <= KEXP;
            ctr <= 4'd1;
          end else if (accept) begin
            fsm <= ROUND;
            ctr <= 4'(AES128_NR - 1);
          end
        end
        ROUND: begin
          if (last_round) begin
            fsm  <= OUT;
            pt_o <= rnd_next;
          end else begin
            ctr <= ctr - 4'd1;
          end
        end
        OUT: begin
          if (pt_ready) fsm <= READY;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

`ifdef AES_DEC_TRIG_EN
  logic trig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trig <= 1'b0;
    else if (accept) trig <= 1'b1;
    else if (last_round) trig <= 1'b0;
  end

  assign trigger_o = trig;
`else
  assign trigger_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_dec_iter_fifo.sv
// Bench for aes128_dec_iter_fifo: an in-bench AES-128 encryptor produces ciphertext for random plaintext,
// and a phase model predicts every handshake/status output each cycle. Honours AES_DEC_TRIG_EN.
module tb_aes128_dec_iter_fifo;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
`ifdef AES_DEC_TRIG_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_load = 1'b0;
  logic [127:0] key_i = '0;
  logic         key_ready;
  logic         ct_valid = 1'b0;
  logic         ct_ready;
  logic [127:0] ct_i = '0;
  logic         pt_valid;
  logic         pt_ready = 1'b0;
  logic [127:0] pt_o;
  logic         busy_o;
  logic         trigger_o;

  int           checks = 0;
  int           errors = 0;
  bit           cmp_en = 1'b0;
  logic [127:0] tb_pt = '0;
  logic [7:0]   sb [256];

  aes128_dec_iter_fifo #(.pROUNDS(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_load  (key_load),
    .key_i     (key_i),
    .key_ready (key_ready),
    .ct_valid  (ct_valid),
    .ct_ready  (ct_ready),
    .ct_i      (ct_i),
    .pt_valid  (pt_valid),
    .pt_ready  (pt_ready),
    .pt_o      (pt_o),
    .busy_o    (busy_o),
    .trigger_o (trigger_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference AES-128 encryptor ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking generator 3 and its inverse through the field.
  task automatic sbox_init();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // ---------------- phase model of the stream interface ----------------
  typedef enum {M_NOKEY, M_EXP, M_RDY, M_DEC, M_HOLD} mmode_t;
  mmode_t       m_mode;
  int           m_left;
  logic [127:0] m_pend;
  logic [127:0] m_pt;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= M_NOKEY;
      m_left <= 0;
      m_pt   <= '0;
    end else begin
      case (m_mode)
        M_NOKEY: if (key_load) begin m_mode <= M_EXP; m_left <= 10; end
        M_EXP:   begin m_left <= m_left - 1; if (m_left == 1) m_mode <= M_RDY; end
        M_RDY: begin
          if (key_load) begin m_mode <= M_EXP; m_left <= 10; end
          else if (ct_valid) begin m_mode <= M_DEC; m_left <= 10; m_pend <= tb_pt; end
        end
        M_DEC: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin m_mode <= M_HOLD; m_pt <= m_pend; end
        end
        M_HOLD:  if (pt_ready) m_mode <= M_RDY;
        default: m_mode <= M_NOKEY;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("key_ready", key_ready, m_mode == M_NOKEY || m_mode == M_RDY);
      chk("ct_ready", ct_ready, m_mode == M_RDY && !key_load);
      chk("pt_valid", pt_valid, m_mode == M_HOLD);
      chk("busy_o", busy_o, m_mode == M_EXP || m_mode == M_DEC);
      chk("pt_o", pt_o, m_pt);
      chk("trigger_o", trigger_o, TRIG && m_mode == M_DEC);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready && n < 40) begin tick(); n++; end
    chk("key_ready_wait", key_ready, 1);
  endtask

  task automatic load_key(input logic [127:0] k);
    wait_ready();
    key_i = k; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_ready();
  endtask

  // Presents one block, returns edges from accept to pt_valid and trigger-high samples seen.
  task automatic send(input logic [127:0] c, input logic [127:0] p, output int lat, output int tc);
    int n = 0;
    ct_i = c; tb_pt = p; ct_valid = 1'b1;
    while (!ct_ready && n < 40) begin tick(); n++; end
    chk("ct_accept_wait", ct_ready, 1);
    tick();
    ct_valid = 1'b0;
    ct_i = {$urandom(), $urandom(), $urandom(), $urandom()};
    tc = int'(trigger_o);
    lat = 0;
    while (!pt_valid && lat < 40) begin tick(); lat++; tc += int'(trigger_o); end
    chk("pt_valid_wait", pt_valid, 1);
  endtask

  task automatic drain();
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] k, p, c, cur;
    int lat, tc, n;
    bit hs;
    sbox_init();
    repeat (3) tick();
    chk("rst_key_ready", key_ready, 1);
    chk("rst_ct_ready", ct_ready, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_pt_o", pt_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_trigger", trigger_o, 0);
    chk("model_fips_c1", encrypt(C1_PT, C1_KEY), C1_CT);
    chk("model_fips_b", encrypt(B_PT, B_KEY), B_CT);
    cmp_en = 1'b1;
    tick();
    reset_n = 1'b1;

    // ciphertext offered with no key loaded is ignored
    ct_i = C1_CT; ct_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); chk("idle_ct_ready", ct_ready, 0); end
    ct_valid = 1'b0;

    // FIPS-197 C.1, with a stray key_load during expansion that must be ignored
    key_i = C1_KEY; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    repeat (3) tick();
    key_i = {4{32'hdeadbeef}}; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    wait_ready();
    pt_ready = 1'b1;
    send(C1_CT, C1_PT, lat, tc);
    // pt_valid rises on the 11th edge counting the accept edge itself
    chk("c1_latency", lat, 10);
    chk("c1_pt", pt_o, C1_PT);
    chk("c1_trigger_cycles", tc, TRIG ? 10 : 0);
    drain();
    chk("c1_pt_retained", pt_o, C1_PT);

    // FIPS-197 B under 20 cycles of backpressure
    load_key(B_KEY);
    send(B_CT, B_PT, lat, tc);
    chk("b_pt", pt_o, B_PT);
    ct_i = C1_CT; ct_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      key_load = (i == 5);
      key_i = {4{32'h5a5a5a5a}};
      tick();
      chk("bp_pt_valid", pt_valid, 1);
      chk("bp_pt_o", pt_o, B_PT);
      chk("bp_ct_ready", ct_ready, 0);
    end
    key_load = 1'b0; ct_valid = 1'b0;
    drain();
    chk("bp_ct_ready_after", ct_ready, 1);
    pt_ready = 1'b1;
    send(B_CT, B_PT, lat, tc);
    chk("b_key_intact", pt_o, B_PT);
    drain();

    // key_load and ct_valid together in READY: key wins, block dropped
    key_i = C1_KEY; key_load = 1'b1; ct_i = B_CT; tb_pt = B_PT; ct_valid = 1'b1;
    tick();
    key_load = 1'b0; ct_valid = 1'b0;
    n = 0;
    while (busy_o && n < 30) begin tick(); n++; end
    chk("collide_busy_cycles", n, 10);
    chk("collide_no_pt", pt_valid, 0);
    pt_ready = 1'b1;
    send(C1_CT, C1_PT, lat, tc);
    chk("collide_new_key_pt", pt_o, C1_PT);
    drain();

    // reset mid-ROUND at r=5
    ct_i = C1_CT; tb_pt = C1_PT; ct_valid = 1'b1;
    n = 0;
    while (!ct_ready && n < 40) begin tick(); n++; end
    tick();
    ct_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_pt_valid", pt_valid, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_key_ready", key_ready, 1);
    chk("midrst_ct_ready", ct_ready, 0);
    tick();
    reset_n = 1'b1;
    ct_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin tick(); chk("nokey_ct_ready", ct_ready, 0); end
    ct_valid = 1'b0;
    load_key(C1_KEY);
    pt_ready = 1'b1;
    send(C1_CT, C1_PT, lat, tc);
    chk("post_rst_pt", pt_o, C1_PT);
    drain();

    // random plaintexts, occasional rekeys, random backpressure
    cur = C1_KEY;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3) == 0) begin
        k = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_key(k);
        cur = k;
      end
      repeat ($urandom_range(2)) tick();
      p = {$urandom(), $urandom(), $urandom(), $urandom()};
      c = encrypt(p, cur);
      pt_ready = 1'($urandom_range(1));
      send(c, p, lat, tc);
      chk("rnd_latency", lat, 10);
      chk("rnd_pt", pt_o, p);
      n = 0; hs = 1'b0;
      while (!hs && n < 100) begin
        hs = pt_ready && pt_valid;
        tick();
        n++;
        if (!hs) pt_ready = 1'($urandom_range(1));
      end
      pt_ready = 1'b0;
      chk("rnd_handshake", hs, 1);
    end

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
